// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, stall/redirect controls and IF/ID outputs.
// master = fetch unit, slave = memory / decode / hazard side.
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [3:0]        if_opcode;
  logic [3:0]        if_funct;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus2;
  logic              halted;

  modport master (
    input  imem_rdata, stall, redirect_valid, redirect_pc,
    output imem_addr, if_valid, if_instr, if_opcode, if_funct, if_pc, if_pc_plus2, halted
  );

  modport slave (
    output imem_rdata, stall, redirect_valid, redirect_pc,
    input  imem_addr, if_valid, if_instr, if_opcode, if_funct, if_pc, if_pc_plus2, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch + IF/ID register; halt detection enabled by FETCH_HALT_DETECT_EN.
// Latency: 1 cycle fetch-to-decode, redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_dat;
  logic [15:0]       instr_dat;
  logic              instr_vld;
  logic              halted_q;
  logic              is_halt;

`ifdef FETCH_HALT_DETECT_EN
  assign is_halt = (bus.imem_rdata[15:12] == 4'b1111);
`else
  assign is_halt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      pc_dat    <= RESET_PC;
      instr_dat <= 16'h0000;
      instr_vld <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            pc        <= bus.redirect_pc;
            instr_vld <= 1'b0;
          end else if (!bus.stall) begin
            instr_dat <= bus.imem_rdata;
            pc_dat    <= pc;
            instr_vld <= 1'b1;
            // a halt word parks the PC on itself until redirected
            if (is_halt) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(2);
            end
          end
        end
        HALTED: begin
          if (bus.redirect_valid) begin
            pc        <= bus.redirect_pc;
            instr_vld <= 1'b0;
            state     <= RUN;
            halted_q  <= 1'b0;
          end else if (!bus.stall) begin
            instr_vld <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_valid    = instr_vld;
  assign bus.if_instr    = instr_dat;
  assign bus.if_opcode   = instr_dat[15:12];
  assign bus.if_funct    = instr_dat[3:0];
  assign bus.if_pc       = pc_dat;
  assign bus.if_pc_plus2 = pc_dat + ADDR_W'(2);
  assign bus.halted      = halted_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and IF/ID pipeline register for the 16-bit CPU. Drives the instruction memory address from the PC and latches the returned 16-bit word. Presents `if_opcode` (bits 15:12) and `if_funct` (bits 3:0) to the control decoder. Also handles sequential PC increment, branch/jump redirect with flush, pipeline stall, and the halt instruction (opcode 4'b1111).

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `ADDR_W`, 16, PC / instruction-memory address width
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `imem_addr` output ADDR_W — instruction memory address; combinationally equal to PC
- `imem_rdata` input 16 — instruction word at `imem_addr`, valid in the same cycle (combinational read)
- `stall` input 1 — hold PC and IF/ID contents
- `redirect_valid` input 1 — taken branch/jump from a later stage
- `redirect_pc` input ADDR_W — redirect target
- `if_valid` output 1 — IF/ID holds a live instruction
- `if_instr` output 16 — latched instruction word
- `if_opcode` output 4 — `if_instr[15:12]`
- `if_funct` output 4 — `if_instr[3:0]`
- `if_pc` output ADDR_W — address of `if_instr`
- `if_pc_plus2` output ADDR_W — `if_pc + 2`, modulo 2^ADDR_W
- `halted` output 1 — fetch is in HALTED state

## Operation
- Byte-addressed, 16-bit instructions; sequential PC step is +2, wrapping modulo 2^ADDR_W (16'hFFFE + 2 = 16'h0000).
- FSM states: RUN, HALTED.
- RUN, each edge, priority order:
  - `redirect_valid`: PC <= `redirect_pc`; `if_valid` <= 0 (flush). Redirect overrides `stall`.
  - else `stall`: PC and all IF/ID registers hold.
  - else: IF/ID <= {`imem_rdata`, PC}; `if_valid` <= 1; PC <= PC + 2.
- Halt detection happens on a non-stalled RUN load whose `imem_rdata[15:12]` == 4'b1111:
  - the halt word is latched with `if_valid`=1;
  - PC does not advance;
  - state becomes HALTED.
- HALTED, each edge:
  - `redirect_valid`: behaves as in RUN (PC <= target, flush), and state returns to RUN. This lets an older branch cancel a speculatively fetched halt.
  - else `stall`: hold everything.
  - else: `if_valid` <= 0; PC, `if_instr`, and `if_pc` hold.
- `if_instr` and `if_pc` keep their last values when `if_valid`=0; consumers must qualify them with `if_valid`.

## Timing
- Reset (asynchronous, while `rst`=1): PC=RESET_PC, `if_valid`=0, `if_instr`=16'h0000, `if_pc`=RESET_PC, state=RUN, `halted`=0. Therefore `if_opcode`=0, `if_funct`=0, `if_pc_plus2`=RESET_PC+2, `imem_addr`=RESET_PC.
- First live instruction appears one edge after `rst` deasserts (the first edge with `stall`=0).
- Fetch-to-decode latency: 1 cycle. Throughput: 1 instruction per cycle when not stalled.
- Redirect penalty: the cycle after the redirect edge shows `if_valid`=0. The target instruction is valid one edge later.
- `halted` is registered and asserts on the same edge that latches the halt word.
- Reset asserted mid-operation (any state): all registers return to reset values immediately, without waiting for `clk`.

## Configuration
- Macro: `FETCH_HALT_DETECT_EN`.
- Defined: halt detection and the HALTED state behave as described above.
- Undefined: opcode 4'b1111 is fetched like any other instruction, the PC keeps incrementing, and `halted` is tied to 0.

## Test plan
- Reset with RESET_PC=16'h0000, memory word[i] = 16'h0i00, run 4 cycles → `if_pc` sequence 0,2,4,6 with `if_valid`=1. `if_opcode` follows the memory contents.
- Assert `stall` for 2 cycles while `if_pc`=16'h0004 → `if_pc` and `if_instr` hold for 2 cycles; `imem_addr` stays 16'h0006. Resumes at 16'h0006.
- `redirect_valid`=1, `redirect_pc`=16'h0040, together with `stall`=1 → next cycle `if_valid`=0 and `imem_addr`=16'h0040. The following cycle `if_pc`=16'h0040.
- Memory word at 16'h0008 = 16'hF000 → `if_opcode`=4'hF and `halted`=1. The next cycle `if_valid`=0, and `imem_addr` stays 16'h0008 indefinitely.
  - Then pulse a redirect to 16'h0010 → `halted`=0 and fetch resumes at 16'h0010.
- PC=16'hFFFE with no stall → `if_pc_plus2`=16'h0000 and the next `imem_addr`=16'h0000.
- Assert `rst` mid-stream, between clock edges → outputs immediately take their reset values.
  - Without `FETCH_HALT_DETECT_EN`, 16'hF000 at 16'h0008 → `halted` stays 0 and the next `if_pc` is 16'h000A.
